hazard_controller: RTL and testbench

Central hazard sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It keeps a shadow copy of the destination/source register fields for EX, MEM and WB, and drives the EX operand forwarding mux selects. It also generates pipeline stall, bubble, flush and freeze controls for load-use hazards, taken branches/jumps and data-memory wait states. It sits beside the pipeline registers and is the only source of their enable/clear controls.

---
 rtl/hazard_controller_if.sv | 33 +++
 rtl/hazard_controller.sv | 121 ++++++++++++
 tb/tb_hazard_controller.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Hazard controller bus: decoded ID-stage information and pipeline status
// flow into the controller; stall/flush/freeze and forwarding selects flow out.
interface hazard_controller_if #(parameter int CNT_W = 16);
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             branch_taken;
    logic             dmem_busy;
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             freeze;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_count;

    // pipeline side: supplies ID/EX status, consumes the controls
    modport master (
        output id_instr, id_valid, id_reg_write, id_mem_read, branch_taken, dmem_busy,
        input  stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, freeze,
               fwd_a_sel, fwd_b_sel, stall_count
    );

    // controller side
    modport slave (
        input  id_instr, id_valid, id_reg_write, id_mem_read, branch_taken, dmem_busy,
        output stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, freeze,
               fwd_a_sel, fwd_b_sel, stall_count
    );
endinterface

// File: rtl/hazard_controller.sv
// Central hazard sequencer for the 5-stage pipeline: tracks register usage of
// the EX/MEM/WB stages, selects EX operand forwarding, and produces the
// stall/bubble/flush/freeze controls for the pipeline registers.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_controller_if.slave bus
);

    typedef enum logic {RUN, FREEZE} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       reg_write;
        logic       mem_read;
    } shadow_t;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    state_t           state;
    logic             pending_flush;
    shadow_t          ex_q, mem_q, wb_q;
    shadow_t          id_entry;
    logic [CNT_W-1:0] stall_cnt;

    logic [6:0] opcode;
    logic       rs1_used, rs2_used;
    logic       load_use;
    logic       freeze_c, flush_c, bubble_c, stall_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    logic unused_bits;
    assign unused_bits = ^{bus.id_instr[31:25], bus.id_instr[14:12],
                           wb_q.rs1, wb_q.rs2, wb_q.mem_read};

    // A stage can forward to rs only when it really writes a nonzero register equal to rs
    function automatic logic can_forward(input shadow_t s, input logic [4:0] rs);
        return s.valid && s.reg_write && (s.rd != 5'd0) && (s.rd == rs);
    endfunction

    // Decode which ID source registers are actually read and form the would-be EX entry
    always_comb begin
        opcode   = bus.id_instr[6:0];
        rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        rs2_used = (opcode == OP_R || opcode == OP_S || opcode == OP_B);
        id_entry.valid     = 1'b1;
        id_entry.rd        = bus.id_instr[11:7];
        id_entry.rs1       = rs1_used ? bus.id_instr[19:15] : 5'd0;
        id_entry.rs2       = rs2_used ? bus.id_instr[24:20] : 5'd0;
        id_entry.reg_write = bus.id_reg_write;
        id_entry.mem_read  = bus.id_mem_read;
    end

    // Hazard resolution: freeze dominates, then branch flush, then load-use stall
    always_comb begin
        load_use = bus.id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
                   (ex_q.rd != 5'd0) &&
                   ((rs1_used && ex_q.rd == id_entry.rs1) ||
                    (rs2_used && ex_q.rd == id_entry.rs2));
        freeze_c = rst_n && bus.dmem_busy;
        flush_c  = rst_n && !bus.dmem_busy &&
                   (bus.branch_taken || (state == FREEZE && pending_flush));
        bubble_c = rst_n && !bus.dmem_busy && !flush_c && load_use;
        stall_c  = freeze_c || bubble_c;
    end

    // Operand forwarding selects; the younger MEM result wins over WB
    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (can_forward(mem_q, ex_q.rs1))      fwd_a_c = 2'b01;
        else if (can_forward(wb_q, ex_q.rs1))  fwd_a_c = 2'b10;
        if (can_forward(mem_q, ex_q.rs2))      fwd_b_c = 2'b01;
        else if (can_forward(wb_q, ex_q.rs2))  fwd_b_c = 2'b10;
    end

    // Run/freeze sequencing, deferred flush, shadow pipeline and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pending_flush <= 1'b0;
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_cnt     <= '0;
        end else begin
            state <= bus.dmem_busy ? FREEZE : RUN;
            if (freeze_c) begin
                pending_flush <= pending_flush || bus.branch_taken;
            end else begin
                pending_flush <= 1'b0;
                wb_q  <= mem_q;
                mem_q <= ex_q;
                if (bubble_c || flush_c || !bus.id_valid) ex_q <= '0;
                else                                       ex_q <= id_entry;
            end
            if (stall_c && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall_if    = stall_c;
    assign bus.stall_id    = stall_c;
    assign bus.bubble_ex   = bubble_c;
    assign bus.flush_if_id = flush_c;
    assign bus.flush_id_ex = flush_c;
    assign bus.freeze      = freeze_c;
    assign bus.fwd_a_sel   = fwd_a_c;
    assign bus.fwd_b_sel   = fwd_b_c;
    assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: directed pipeline scenarios plus random
// instruction streams compared against a stage-slot reference model.
module tb_hazard_controller;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_controller_if #(.CNT_W(CNT_W)) hif();
    hazard_controller #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(hif.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: one slot per downstream stage
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit [4:0] src1;
        bit [4:0] src2;
        bit       writes;
        bit       loads;
    } slot_t;

    slot_t m_ex, m_mem, m_wb;
    bit    m_pend;
    int    m_cnt;
    bit    e_stall, e_bubble, e_flush, e_freeze;
    bit [1:0] e_fa, e_fb;

    function automatic bit [31:0] r_op(input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic bit [31:0] lw_op(input bit [4:0] rd, input bit [4:0] rs1);
        return {12'b0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic bit [31:0] sw_op(input bit [4:0] rs1, input bit [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
    endfunction
    function automatic bit [31:0] lui_op(input bit [4:0] rd);
        return {20'h12345, rd, 7'b0110111};
    endfunction

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{valid: 0, rd: 0, src1: 0, src2: 0, writes: 0, loads: 0};
        return s;
    endfunction

    // what the ID instruction would look like once it moves into EX
    function automatic slot_t id_slot();
        slot_t s;
        bit [6:0] op;
        op = hif.id_instr[6:0];
        s.valid  = 1;
        s.rd     = hif.id_instr[11:7];
        s.src1   = (op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111) ? 5'd0 : hif.id_instr[19:15];
        s.src2   = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011) ? hif.id_instr[24:20] : 5'd0;
        s.writes = hif.id_reg_write;
        s.loads  = hif.id_mem_read;
        return s;
    endfunction

    function automatic bit [1:0] model_fwd(input bit [4:0] rs);
        if (rs != 0 && m_mem.valid && m_mem.writes && m_mem.rd == rs) return 2'b01;
        if (rs != 0 && m_wb.valid && m_wb.writes && m_wb.rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_ex = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot();
        m_pend = 0;
        m_cnt = 0;
    endtask

    task automatic model_eval();
        slot_t nxt;
        bit lu;
        nxt = id_slot();
        lu = hif.id_valid && m_ex.valid && m_ex.loads && m_ex.writes && m_ex.rd != 0 &&
             (m_ex.rd == nxt.src1 || m_ex.rd == nxt.src2);
        e_freeze = hif.dmem_busy;
        e_flush  = !hif.dmem_busy && (hif.branch_taken || m_pend);
        e_bubble = !hif.dmem_busy && !e_flush && lu;
        e_stall  = e_freeze || e_bubble;
        e_fa = model_fwd(m_ex.src1);
        e_fb = model_fwd(m_ex.src2);
    endtask

    task automatic model_advance();
        model_eval();
        if (!hif.dmem_busy) begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (e_bubble || e_flush || !hif.id_valid) ? empty_slot() : id_slot();
            m_pend = 0;
        end else begin
            m_pend = m_pend || hif.branch_taken;
        end
        if (e_stall && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic drive(input bit [31:0] instr, input bit valid, input bit bt, input bit busy);
        bit [6:0] op;
        op = instr[6:0];
        hif.id_instr     = instr;
        hif.id_valid     = valid;
        hif.id_reg_write = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                      7'b0010111, 7'b1101111, 7'b1100111};
        hif.id_mem_read  = (op == 7'b0000011);
        hif.branch_taken = bt;
        hif.dmem_busy    = busy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(NOP, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(lw_op(5, 1), 1, 1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({hif.stall_if, hif.bubble_ex, hif.flush_if_id, hif.flush_id_ex, hif.freeze,
             hif.fwd_a_sel, hif.fwd_b_sel, hif.stall_count} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_hold: outputs not all zero (freeze=%b flush=%b cnt=%0d), want 0",
                     hif.freeze, hif.flush_if_id, hif.stall_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        drive(NOP, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({hif.stall_if, hif.stall_id, hif.bubble_ex, hif.flush_if_id, hif.freeze,
             hif.fwd_a_sel, hif.fwd_b_sel, hif.stall_count} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_after: outputs not all zero (stall=%b fa=%b cnt=%0d), want 0",
                     hif.stall_if, hif.fwd_a_sel, hif.stall_count);
        end
        tick();
    endtask

    task automatic test_forwarding();
        do_reset();
        drive(r_op(5, 1, 2), 1, 0, 0); tick();
        drive(r_op(6, 5, 3), 1, 0, 0); tick();
        drive(NOP, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (hif.fwd_a_sel !== 2'b01) begin
            n_bad++; $display("[TB] FAIL fwd_mem_a: got %b want 01", hif.fwd_a_sel);
        end
        tick();
        drive(r_op(5, 1, 2), 1, 0, 0); tick();
        drive(NOP, 1, 0, 0); tick();
        drive(r_op(6, 5, 3), 1, 0, 0); tick();
        drive(NOP, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (hif.fwd_a_sel !== 2'b10) begin
            n_bad++; $display("[TB] FAIL fwd_wb_a: got %b want 10", hif.fwd_a_sel);
        end
        tick();
        drive(r_op(0, 1, 2), 1, 0, 0); tick();
        drive(r_op(6, 0, 3), 1, 0, 0); tick();
        drive(NOP, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (hif.fwd_a_sel !== 2'b00) begin
            n_bad++; $display("[TB] FAIL fwd_x0: got %b want 00", hif.fwd_a_sel);
        end
        tick();
        drive(r_op(7, 1, 2), 1, 0, 0); tick();
        drive(r_op(7, 3, 4), 1, 0, 0); tick();
        drive(r_op(6, 7, 7), 1, 0, 0); tick();
        drive(NOP, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({hif.fwd_a_sel, hif.fwd_b_sel} !== 4'b0101) begin
            n_bad++; $display("[TB] FAIL fwd_priority: got a=%b b=%b want a=01 b=01", hif.fwd_a_sel, hif.fwd_b_sel);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(lw_op(5, 1), 1, 0, 0); tick();
        drive(r_op(6, 5, 7), 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({hif.stall_if, hif.stall_id, hif.bubble_ex, hif.flush_if_id} !== 4'b1110) begin
            n_bad++; $display("[TB] FAIL load_use_stall: got stall_if/id/bubble/flush=%b%b%b%b want 1110",
                              hif.stall_if, hif.stall_id, hif.bubble_ex, hif.flush_if_id);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({hif.stall_if, hif.bubble_ex} !== 2'b00) begin
            n_bad++; $display("[TB] FAIL load_use_once: got stall_if=%b bubble=%b want 0 0", hif.stall_if, hif.bubble_ex);
        end
        tick();
        drive(NOP, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (hif.fwd_a_sel !== 2'b10) begin
            n_bad++; $display("[TB] FAIL load_use_fwd: got %b want 10", hif.fwd_a_sel);
        end
        n_cmp++;
        if (hif.stall_count !== CNT_W'(1)) begin
            n_bad++; $display("[TB] FAIL load_use_count: got %0d want 1", hif.stall_count);
        end
        tick();
    endtask

    task automatic test_source_decode();
        do_reset();
        drive(lw_op(5, 1), 1, 0, 0); tick();
        drive(lui_op(5), 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (hif.stall_if !== 1'b0) begin
            n_bad++; $display("[TB] FAIL lui_no_stall: got %b want 0", hif.stall_if);
        end
        tick();
        drive(NOP, 1, 0, 0); tick(); tick();
        drive(lw_op(5, 1), 1, 0, 0); tick();
        drive(sw_op(1, 5), 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({hif.stall_if, hif.bubble_ex} !== 2'b11) begin
            n_bad++; $display("[TB] FAIL sw_rs2_stall: got stall=%b bubble=%b want 1 1", hif.stall_if, hif.bubble_ex);
        end
        tick();
        drive(NOP, 1, 0, 0); tick();
    endtask

    task automatic test_branch_override();
        do_reset();
        drive(lw_op(5, 1), 1, 0, 0); tick();
        drive(r_op(6, 5, 7), 1, 1, 0);
        @(negedge clk);
        n_cmp++;
        if ({hif.flush_if_id, hif.flush_id_ex, hif.stall_if, hif.stall_id, hif.bubble_ex} !== 5'b11000) begin
            n_bad++; $display("[TB] FAIL branch_override: got flush=%b%b stall=%b%b bubble=%b want 11 00 0",
                              hif.flush_if_id, hif.flush_id_ex, hif.stall_if, hif.stall_id, hif.bubble_ex);
        end
        tick();
        drive(r_op(8, 6, 1), 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({hif.stall_if, hif.flush_if_id} !== 2'b00) begin
            n_bad++; $display("[TB] FAIL branch_single: got stall=%b flush=%b want 0 0", hif.stall_if, hif.flush_if_id);
        end
        tick();
        drive(NOP, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (hif.fwd_a_sel !== 2'b00) begin
            n_bad++; $display("[TB] FAIL branch_ex_invalid: got fwd_a=%b want 00", hif.fwd_a_sel);
        end
        tick();
    endtask

    task automatic test_freeze();
        do_reset();
        drive(r_op(5, 1, 2), 1, 0, 0); tick();
        drive(r_op(6, 5, 3), 1, 0, 0); tick();
        for (int c = 0; c < 3; c++) begin
            drive(NOP, 1, (c == 1), 1);
            @(negedge clk);
            n_cmp++;
            if ({hif.freeze, hif.stall_if, hif.stall_id, hif.bubble_ex, hif.flush_if_id, hif.flush_id_ex,
                 hif.fwd_a_sel} !== 8'b11100001) begin
                n_bad++; $display("[TB] FAIL freeze_cycle%0d: got frz=%b stall=%b bub=%b flush=%b fa=%b want 1 1 0 0 01",
                                  c, hif.freeze, hif.stall_if, hif.bubble_ex, hif.flush_if_id, hif.fwd_a_sel);
            end
            tick();
        end
        drive(NOP, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if ({hif.freeze, hif.flush_if_id, hif.flush_id_ex} !== 3'b011) begin
            n_bad++; $display("[TB] FAIL freeze_release_flush: got frz=%b flush=%b%b want 0 11",
                              hif.freeze, hif.flush_if_id, hif.flush_id_ex);
        end
        n_cmp++;
        if (hif.stall_count !== CNT_W'(3)) begin
            n_bad++; $display("[TB] FAIL freeze_count: got %0d want 3", hif.stall_count);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (hif.flush_if_id !== 1'b0) begin
            n_bad++; $display("[TB] FAIL pending_cleared: got flush=%b want 0", hif.flush_if_id);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        drive(NOP, 1, 0, 1);
        repeat (CNT_MAX + 5) tick();
        drive(NOP, 1, 0, 0);
        @(negedge clk);
        n_cmp++;
        if (hif.stall_count !== CNT_W'(CNT_MAX)) begin
            n_bad++; $display("[TB] FAIL count_saturate: got %0d want %0d", hif.stall_count, CNT_MAX);
        end
        tick();
    endtask

    task automatic test_reset_mid_freeze();
        do_reset();
        drive(NOP, 1, 0, 1); tick();
        drive(NOP, 1, 1, 1); tick();
        drive(lw_op(5, 1), 1, 1, 1);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({hif.stall_if, hif.stall_id, hif.bubble_ex, hif.flush_if_id, hif.flush_id_ex, hif.freeze,
             hif.fwd_a_sel, hif.fwd_b_sel, hif.stall_count} !== '0) begin
            n_bad++; $display("[TB] FAIL reset_async: got frz=%b stall=%b cnt=%0d want all 0",
                              hif.freeze, hif.stall_if, hif.stall_count);
        end
        model_reset();
        drive(NOP, 1, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({hif.freeze, hif.flush_if_id, hif.flush_id_ex, hif.stall_count} !== '0) begin
            n_bad++; $display("[TB] FAIL reset_clears_pending: got frz=%b flush=%b%b cnt=%0d want 0",
                              hif.freeze, hif.flush_if_id, hif.flush_id_ex, hif.stall_count);
        end
        tick();
    endtask

    task automatic test_random(input int cycles);
        bit [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        int busy_left;
        bit [31:0] instr;
        logic [CNT_W+9:0] got, want;
        busy_left = 0;
        do_reset();
        for (int i = 0; i < cycles; i++) begin
            instr = {7'($urandom), 2'b00, 3'($urandom), 2'b00, 3'($urandom), 3'($urandom),
                     2'b00, 3'($urandom), ops[$urandom_range(0, 8)]};
            if (busy_left == 0 && $urandom_range(0, 99) < 10) busy_left = $urandom_range(1, 4);
            drive(instr, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), (busy_left != 0));
            if (busy_left != 0) busy_left--;
            @(negedge clk);
            model_eval();
            want = {e_stall, e_stall, e_bubble, e_flush, e_flush, e_freeze, e_fa, e_fb, CNT_W'(m_cnt)};
            got  = {hif.stall_if, hif.stall_id, hif.bubble_ex, hif.flush_if_id, hif.flush_id_ex,
                    hif.freeze, hif.fwd_a_sel, hif.fwd_b_sel, hif.stall_count};
            n_cmp++;
            if (got !== want) begin
                n_bad++; $display("[TB] FAIL random_cycle%0d: got %b want %b", i, got, want);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(NOP, 0, 0, 0);
        model_reset();
        test_reset();
        test_forwarding();
        test_load_use();
        test_source_decode();
        test_branch_override();
        test_freeze();
        test_saturation();
        test_reset_mid_freeze();
        test_random(300);
        test_random(40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
